// File: rtl/butterfly_row_loader_if.sv
// Element-stream and row-output bundle between the row loader and its neighbours.
// The master drives the element stream; the slave (loader) returns ready and the assembled row.
interface butterfly_row_loader_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 16
);
  localparam int NUM_SWITCHES = NUM_INPUTS / 2;
  localparam int IDX_WIDTH    = $clog2(NUM_INPUTS);

  logic                                   s_val;
  logic                                   s_rdy;
  logic [DATA_WIDTH-1:0]                  s_data;
  logic                                   s_last;
  logic                                   out_val;
  logic [0:NUM_INPUTS-1][DATA_WIDTH-1:0]  output_elements;
  logic [NUM_SWITCHES-1:0]                ctrls;
  logic [IDX_WIDTH-1:0]                   row_idx;

  modport master (
    output s_val, s_data, s_last,
    input  s_rdy, out_val, output_elements, ctrls, row_idx
  );

  modport slave (
    input  s_val, s_data, s_last,
    output s_rdy, out_val, output_elements, ctrls, row_idx
  );
endinterface

// File: rtl/butterfly_row_loader.sv
// Packs a scalar element stream into NUM_INPUTS-wide rows for the first butterfly stage.
// Row emitted one edge after its last element; s_rdy stays high since emit and fill overlap.
module butterfly_row_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 16,
  parameter int STAGE      = 0
) (
  input logic                clk,
  input logic                rst_n,
  butterfly_row_loader_if.slave bus
);
  localparam int NUM_SWITCHES = NUM_INPUTS / 2;
  localparam int IDX_WIDTH    = $clog2(NUM_INPUTS);
  localparam logic [IDX_WIDTH-1:0] LAST_PTR = IDX_WIDTH'(NUM_INPUTS - 1);

  typedef logic [0:NUM_INPUTS-1][DATA_WIDTH-1:0] row_t;

  logic                    s_rdy_q, s_rdy_d;
  logic                    out_val_q, out_val_d;
  row_t                    out_row_q, out_row_d;
  logic [NUM_SWITCHES-1:0] ctrls_q, ctrls_d;
  logic [IDX_WIDTH-1:0]    row_idx_q, row_idx_d;
  logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
  row_t                    fill_q, fill_d;
  logic [IDX_WIDTH-1:0]    row_cnt_q, row_cnt_d;

  logic accept;
  logic complete;
  row_t fill_row;

  always_comb begin
    accept   = bus.s_val && s_rdy_q;
    complete = accept && ((ptr_q == LAST_PTR) || bus.s_last);
    // Slots past the current element are already zero because the buffer clears per row.
    fill_row        = fill_q;
    fill_row[ptr_q] = bus.s_data;

    s_rdy_d   = 1'b1;
    out_val_d = complete;
    out_row_d = out_row_q;
    ctrls_d   = ctrls_q;
    row_idx_d = row_idx_q;
    ptr_d     = ptr_q;
    fill_d    = fill_q;
    row_cnt_d = row_cnt_q;

    if (complete) begin
      out_row_d = fill_row;
      row_idx_d = row_cnt_q;
      ctrls_d   = {NUM_SWITCHES{row_cnt_q[STAGE]}};
      ptr_d     = '0;
      fill_d    = '0;
      row_cnt_d = bus.s_last ? '0 : row_cnt_q + IDX_WIDTH'(1);
    end else if (accept) begin
      fill_d = fill_row;
      ptr_d  = ptr_q + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rdy_q   <= 1'b0;
      out_val_q <= 1'b0;
      out_row_q <= '0;
      ctrls_q   <= '0;
      row_idx_q <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      row_cnt_q <= '0;
    end else begin
      s_rdy_q   <= s_rdy_d;
      out_val_q <= out_val_d;
      out_row_q <= out_row_d;
      ctrls_q   <= ctrls_d;
      row_idx_q <= row_idx_d;
      ptr_q     <= ptr_d;
      fill_q    <= fill_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign bus.s_rdy           = s_rdy_q;
  assign bus.out_val         = out_val_q;
  assign bus.output_elements = out_row_q;
  assign bus.ctrls           = ctrls_q;
  assign bus.row_idx         = row_idx_q;
endmodule

// File: tb/tb_butterfly_row_loader.sv
// Bench for butterfly_row_loader: two instances (STAGE 0 and STAGE 2) share one stream
// and are checked against a queue-based row model.
module tb_butterfly_row_loader;
  localparam int DW = 64;
  localparam int N  = 16;
  localparam int NS = 8;
  typedef logic [0:N-1][DW-1:0] row_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          tb_val  = 1'b0;
  logic          tb_last = 1'b0;
  logic [DW-1:0] tb_data = '0;

  always #5 clk = ~clk;

  butterfly_row_loader_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) if0 ();
  butterfly_row_loader_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) if2 ();

  assign if0.s_val  = tb_val;
  assign if0.s_data = tb_data;
  assign if0.s_last = tb_last;
  assign if2.s_val  = tb_val;
  assign if2.s_data = tb_data;
  assign if2.s_last = tb_last;

  butterfly_row_loader #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .STAGE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  butterfly_row_loader #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .STAGE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a row is simply the list of elements accepted since the last completion.
  logic [DW-1:0] cur[$];
  int            row_cnt  = 0;
  row_t          held_row = '0;
  int            held_idx = 0;

  always @(posedge clk) cyc++;

  function automatic void model_reset();
    cur.delete();
    row_cnt  = 0;
    held_row = '0;
    held_idx = 0;
  endfunction

  // Drives one cycle from a negedge, updates the model, returns at the next negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, output logic pulse);
    pulse   = 1'b0;
    tb_val  = v;
    tb_data = d;
    tb_last = l;
    if (v) begin
      cur.push_back(d);
      if (cur.size() == N || l) begin
        pulse    = 1'b1;
        held_row = '0;
        foreach (cur[k]) held_row[k] = cur[k];
        held_idx = row_cnt;
        row_cnt  = l ? 0 : (row_cnt + 1) % N;
        cur.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
    tb_val  = 1'b0;
    tb_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    tb_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    row_t zero_row;
    zero_row = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (if0.s_rdy !== 1'b0 || if0.out_val !== 1'b0 || if2.s_rdy !== 1'b0 || if2.out_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs s_rdy=%b/%b out_val=%b/%b expected 0", if0.s_rdy, if2.s_rdy, if0.out_val, if2.out_val);
    end
    checks++;
    if (if0.output_elements !== zero_row || if0.row_idx !== 4'd0 || if0.ctrls !== 8'h00 || if2.ctrls !== 8'h00) begin
      errors++;
      $display("FAIL reset_out row_idx=%h ctrls=%h/%h expected zeros", if0.row_idx, if0.ctrls, if2.ctrls);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (if0.s_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_hold s_rdy=%b expected 0 before first edge", if0.s_rdy);
    end
    @(negedge clk);
    checks++;
    if (if0.s_rdy !== 1'b1 || if2.s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_rise s_rdy=%b/%b expected 1", if0.s_rdy, if2.s_rdy);
    end
    model_reset();
  endtask

  task automatic test_single_row();
    logic p;
    int   bad;
    do_reset();
    for (int k = 0; k < N; k++) begin
      step(1'b1, DW'(64'h10 + k), 1'b0, p);
      checks++;
      if (if0.out_val !== p) begin
        errors++;
        $display("FAIL single_pulse elem=%0d out_val=%b expected %b", k, if0.out_val, p);
      end
    end
    bad = -1;
    for (int k = 0; k < N; k++) if (bad < 0 && if0.output_elements[k] !== DW'(64'h10 + k)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL single_row slot=%0d got %h expected %h", bad, if0.output_elements[bad], DW'(64'h10 + bad));
    end
    checks++;
    if (if0.row_idx !== 4'd0 || if0.ctrls !== 8'h00) begin
      errors++;
      $display("FAIL single_idx row_idx=%0d ctrls=%h expected 0/00", if0.row_idx, if0.ctrls);
    end
    step(1'b0, '0, 1'b0, p);
    checks++;
    if (if0.out_val !== 1'b0) begin
      errors++;
      $display("FAIL single_fall out_val=%b expected 0", if0.out_val);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    int   pulse_cyc[$];
    int   bad;
    do_reset();
    for (int k = 0; k < 2 * N; k++) begin
      step(1'b1, DW'(k), 1'b0, p);
      if (if0.out_val === 1'b1) begin
        pulse_cyc.push_back(cyc);
        bad = -1;
        for (int s = 0; s < N; s++) if (bad < 0 && if0.output_elements[s] !== held_row[s]) bad = s;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL b2b_row slot=%0d got %h expected %h", bad, if0.output_elements[bad], held_row[bad]);
        end
      end
    end
    checks++;
    if (pulse_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count pulses=%0d expected 2", pulse_cyc.size());
    end else begin
      checks++;
      if (pulse_cyc[1] - pulse_cyc[0] != N) begin
        errors++;
        $display("FAIL b2b_gap gap=%0d expected %0d", pulse_cyc[1] - pulse_cyc[0], N);
      end
    end
    checks++;
    if (if0.row_idx !== 4'd1 || if0.ctrls !== 8'hFF || if2.ctrls !== 8'h00) begin
      errors++;
      $display("FAIL b2b_idx row_idx=%0d ctrls0=%h ctrls2=%h expected 1/FF/00", if0.row_idx, if0.ctrls, if2.ctrls);
    end
  endtask

  task automatic test_short_row();
    logic p;
    int   bad;
    row_t exp_row;
    do_reset();
    step(1'b1, 64'hA0, 1'b0, p);
    step(1'b1, 64'hA1, 1'b0, p);
    step(1'b0, 64'hEE, 1'b1, p);
    checks++;
    if (if0.out_val !== 1'b0) begin
      errors++;
      $display("FAIL short_ignored_last out_val=%b expected 0", if0.out_val);
    end
    step(1'b1, 64'hA2, 1'b1, p);
    checks++;
    if (if0.out_val !== 1'b1) begin
      errors++;
      $display("FAIL short_pulse out_val=%b expected 1", if0.out_val);
    end
    exp_row = '0;
    exp_row[0] = 64'hA0;
    exp_row[1] = 64'hA1;
    exp_row[2] = 64'hA2;
    bad = -1;
    for (int s = 0; s < N; s++) if (bad < 0 && if0.output_elements[s] !== exp_row[s]) bad = s;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL short_row slot=%0d got %h expected %h", bad, if0.output_elements[bad], exp_row[bad]);
    end
    // Full row that also ends the matrix, then a short row: both must restart at index 0.
    for (int k = 0; k < N; k++) step(1'b1, DW'(64'hB0 + k), (k == N - 1), p);
    checks++;
    if (if0.out_val !== 1'b1 || if0.row_idx !== 4'd0 || if0.output_elements[N-1] !== DW'(64'hBF)) begin
      errors++;
      $display("FAIL short_next out_val=%b row_idx=%0d last=%h expected 1/0/bf", if0.out_val, if0.row_idx, if0.output_elements[N-1]);
    end
    step(1'b1, 64'hC0, 1'b1, p);
    checks++;
    if (if0.out_val !== 1'b1 || if0.row_idx !== 4'd0 || if0.output_elements[1] !== '0) begin
      errors++;
      $display("FAIL short_after_full out_val=%b row_idx=%0d slot1=%h expected 1/0/0", if0.out_val, if0.row_idx, if0.output_elements[1]);
    end
  endtask

  task automatic test_row_wrap();
    logic       p;
    logic [7:0] exp0;
    logic [7:0] exp2;
    do_reset();
    for (int r = 0; r < N + 1; r++) begin
      for (int k = 0; k < N; k++) step(1'b1, {$urandom, $urandom}, 1'b0, p);
      exp0 = (r % 2 == 1) ? 8'hFF : 8'h00;
      exp2 = ((r % N) % 8 >= 4) ? 8'hFF : 8'h00;
      checks++;
      if (if0.out_val !== 1'b1 || if0.row_idx !== 4'(r % N)) begin
        errors++;
        $display("FAIL wrap_idx row=%0d out_val=%b row_idx=%0d expected 1/%0d", r, if0.out_val, if0.row_idx, r % N);
      end
      checks++;
      if (if0.ctrls !== exp0 || if2.ctrls !== exp2) begin
        errors++;
        $display("FAIL wrap_ctrls row=%0d ctrls0=%h ctrls2=%h expected %h/%h", r, if0.ctrls, if2.ctrls, exp0, exp2);
      end
    end
  endtask

  task automatic test_random_gaps();
    logic          p;
    logic          v;
    logic          l;
    int            done;
    int            bad;
    done = 0;
    do_reset();
    for (int c = 0; c < 400 && done < 3; c++) begin
      v = 1'($urandom_range(0, 1));
      l = v ? 1'b0 : 1'($urandom_range(0, 1));
      step(v, {$urandom, $urandom}, l, p);
      if (p) done++;
      checks++;
      if (if0.out_val !== p || if2.out_val !== p || if0.s_rdy !== 1'b1) begin
        errors++;
        $display("FAIL gaps_pulse cyc=%0d out_val=%b/%b s_rdy=%b expected %b/%b/1", cyc, if0.out_val, if2.out_val, if0.s_rdy, p, p);
      end
      bad = -1;
      for (int s = 0; s < N; s++)
        if (bad < 0 && (if0.output_elements[s] !== held_row[s] || if2.output_elements[s] !== held_row[s])) bad = s;
      checks++;
      if (bad >= 0 || if0.row_idx !== 4'(held_idx)) begin
        errors++;
        $display("FAIL gaps_row cyc=%0d slot=%0d row_idx=%0d expected idx %0d", cyc, bad, if0.row_idx, held_idx);
      end
    end
    checks++;
    if (done < 3) begin
      errors++;
      $display("FAIL gaps_timeout rows=%0d expected 3", done);
    end
  endtask

  task automatic test_reset_mid_row();
    logic p;
    int   bad;
    row_t zero_row;
    zero_row = '0;
    for (int k = 0; k < 7; k++) step(1'b1, DW'(64'hD0 + k), 1'b0, p);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.s_rdy !== 1'b0 || if0.out_val !== 1'b0 || if0.output_elements !== zero_row ||
        if0.row_idx !== 4'd0 || if0.ctrls !== 8'h00 || if2.ctrls !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async s_rdy=%b out_val=%b row_idx=%0d ctrls=%h/%h expected zeros",
               if0.s_rdy, if0.out_val, if0.row_idx, if0.ctrls, if2.ctrls);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if0.s_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rdy s_rdy=%b expected 1", if0.s_rdy);
    end
    for (int k = 0; k < N; k++) begin
      step(1'b1, DW'(64'hE0 + k), 1'b0, p);
      checks++;
      if (if0.out_val !== p) begin
        errors++;
        $display("FAIL midrst_pulse elem=%0d out_val=%b expected %b", k, if0.out_val, p);
      end
    end
    bad = -1;
    for (int s = 0; s < N; s++) if (bad < 0 && if0.output_elements[s] !== DW'(64'hE0 + s)) bad = s;
    checks++;
    if (bad >= 0 || if0.row_idx !== 4'd0) begin
      errors++;
      $display("FAIL midrst_row slot=%0d row_idx=%0d expected no stale data and idx 0", bad, if0.row_idx);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_short_row();
    test_row_wrap();
    test_random_gaps();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
